// File: rtl/boot_rom_ctrl_pkg.sv
// Shared types and constants for the boot ROM bus controller.
// The default ROM word-address width can be overridden by defining ROM_ADDR_WIDTH.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 10
`endif

package boot_rom_ctrl_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    localparam logic [31:0] ROM_BASE_DEFAULT = 32'h0000_8000;

endpackage

// File: rtl/boot_rom_ctrl_rsp_fifo.sv
// In-order response FIFO of rsp_t entries with occupancy output.
// A push and a pop in the same cycle leave the occupancy unchanged.
module rsp_fifo
    import boot_rom_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rsp_t             push_data,
    input  logic             pop,
    output rsp_t             head,
    output logic [CNT_W-1:0] occ
);

    rsp_t             mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] occ_reg;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    assign head = mem_reg[rd_ptr_reg];
    assign occ  = occ_reg;

endmodule

// File: rtl/boot_rom_ctrl.sv
// Bus-side boot ROM controller: grant/decode, one-cycle ROM enable, and
// in-order responses through a bypass path plus a small response buffer.
module boot_rom_ctrl
    import boot_rom_ctrl_pkg::*;
#(
    parameter int          ROM_ADDR_WIDTH = `ROM_ADDR_WIDTH,
    parameter logic [31:0] ROM_BASE       = ROM_BASE_DEFAULT,
    parameter int          RSP_DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [31:0]               addr_i,
    input  logic                      we_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic                      rom_en_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [31:0]               rom_rdata_i
);

    localparam int          CNT_W    = $clog2(RSP_DEPTH + 1);
    localparam logic [32:0] ROM_END  = {1'b0, ROM_BASE} + (33'd4 << ROM_ADDR_WIDTH);
    localparam logic [CNT_W:0] DEPTH_LV = RSP_DEPTH[CNT_W:0];

    logic             inflight_reg;
    logic             inflight_err_reg;
    logic [CNT_W-1:0] occ;
    logic [CNT_W:0]   level;
    logic             in_range;
    logic             acc_err;
    logic             accept;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    rsp_t             bypass_rsp;
    rsp_t             head_rsp;
    rsp_t             out_rsp;

    // Everything accepted but not yet consumed counts against the buffer,
    // so the FIFO can never overflow.
    assign level  = {1'b0, occ} + {{CNT_W{1'b0}}, inflight_reg};
    assign gnt_o  = req_i & rst_n & (level < DEPTH_LV);
    assign accept = gnt_o;

    assign in_range = (addr_i >= ROM_BASE) && ({1'b0, addr_i} < ROM_END);
    assign acc_err  = we_i | ~in_range | (addr_i[1:0] != 2'b00);

    // ROM_BASE is word aligned, so the word offset needs no borrow from bits [1:0].
    assign rom_en_o   = accept & ~acc_err;
    assign rom_addr_o = rom_en_o ? (addr_i[ROM_ADDR_WIDTH+1:2] - ROM_BASE[ROM_ADDR_WIDTH+1:2])
                                 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg     <= 1'b0;
            inflight_err_reg <= 1'b0;
        end else begin
            inflight_reg     <= accept;
            inflight_err_reg <= accept & acc_err;
        end
    end

    always_comb begin
        bypass_rsp.err  = inflight_err_reg;
        bypass_rsp.data = inflight_err_reg ? 32'h0 : rom_rdata_i;
    end

    // An empty buffer lets the returning word through; it is parked only if not taken.
    assign fifo_empty = (occ == '0);
    assign push       = inflight_reg & ~(fifo_empty & rready_i);
    assign pop        = ~fifo_empty & rready_i;
    assign out_rsp    = fifo_empty ? bypass_rsp : head_rsp;

    assign rvalid_o = inflight_reg | ~fifo_empty;
    assign rdata_o  = rvalid_o ? out_rsp.data : 32'h0;
    assign err_o    = rvalid_o & out_rsp.err;

    rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bypass_rsp),
        .pop       (pop),
        .head      (head_rsp),
        .occ       (occ)
    );

endmodule

// File: tb/tb_boot_rom_ctrl.sv
// Self-checking bench for boot_rom_ctrl: directed scenarios with literal checks
// plus randomized traffic compared every cycle against a queue-based model.
module tb_boot_rom_ctrl;

    localparam int          AW        = 10;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] BASE      = 32'h0000_8000;
    localparam logic [31:0] ROM_LIMIT = BASE + 32'(4 << AW);

    logic          clk;
    logic          rst_n;
    logic          req_i;
    logic          gnt_o;
    logic [31:0]   addr_i;
    logic          we_i;
    logic          rvalid_o;
    logic          rready_i;
    logic [31:0]   rdata_o;
    logic          err_o;
    logic          rom_en_o;
    logic [AW-1:0] rom_addr_o;
    logic [31:0]   rom_rdata_i;

    int checks   = 0;
    int failures = 0;

    // Expected responses, oldest first: {err, data}
    logic [32:0] exp_q[$];

    boot_rom_ctrl #(
        .ROM_ADDR_WIDTH (AW),
        .ROM_BASE       (BASE),
        .RSP_DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .rom_en_o    (rom_en_o),
        .rom_addr_o  (rom_addr_o),
        .rom_rdata_i (rom_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] w);
        return 32'hA500_0000 | 32'(w);
    endfunction

    // ROM: data one cycle after enable, garbage otherwise
    always @(posedge clk) begin
        rom_rdata_i <= rom_en_o ? rom_word(rom_addr_o) : 32'hDEAD_BEEF;
    end

    function automatic logic is_err(input logic [31:0] a, input logic w);
        return w || (a < BASE) || (a >= ROM_LIMIT) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [AW-1:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return off[AW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Per-cycle model: outstanding responses = accepted minus consumed
    always @(negedge clk) begin
        logic exp_gnt;
        logic exp_valid;
        logic e;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_gnt", 32'(gnt_o), 32'd0);
            chk("rst_rvalid", 32'(rvalid_o), 32'd0);
            chk("rst_rdata", rdata_o, 32'd0);
            chk("rst_err", 32'(err_o), 32'd0);
            chk("rst_rom_en", 32'(rom_en_o), 32'd0);
        end else begin
            exp_gnt   = req_i && (exp_q.size() < DEPTH);
            exp_valid = exp_q.size() > 0;
            e         = is_err(addr_i, we_i);
            chk("m_gnt", 32'(gnt_o), 32'(exp_gnt));
            chk("m_rvalid", 32'(rvalid_o), 32'(exp_valid));
            if (exp_valid) begin
                chk("m_rdata", rdata_o, exp_q[0][31:0]);
                chk("m_err", 32'(err_o), 32'(exp_q[0][32]));
            end
            chk("m_rom_en", 32'(rom_en_o), 32'(exp_gnt && !e));
            if (exp_gnt && !e) begin
                chk("m_rom_addr", 32'(rom_addr_o), 32'(word_of(addr_i)));
            end
            if (exp_valid && rready_i) begin
                void'(exp_q.pop_front());
            end
            if (exp_gnt) begin
                exp_q.push_back(e ? {1'b1, 32'h0} : {1'b0, rom_word(word_of(addr_i))});
            end
        end
    end

    task automatic set_in(input logic r, input logic [31:0] a, input logic w, input logic rr);
        req_i    = r;
        addr_i   = a;
        we_i     = w;
        rready_i = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_read();
        set_in(1'b1, BASE + 32'd8, 1'b0, 1'b1);
        @(negedge clk);
        chk("s1_gnt", 32'(gnt_o), 32'd1);
        chk("s1_rom_en", 32'(rom_en_o), 32'd1);
        chk("s1_rom_addr", 32'(rom_addr_o), 32'd2);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("s1_rvalid", 32'(rvalid_o), 32'd1);
        chk("s1_rdata", rdata_o, 32'hA500_0002);
        chk("s1_err", 32'(err_o), 32'd0);
        tick();
        $display("txn single read word2 rdata=%h", 32'hA500_0002);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, BASE, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst_rom_addr", 32'(rom_addr_o), 32'd0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        $display("txn reset released");

        single_read();

        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, BASE + 32'(4 * i), 1'b0, 1'b1);
            @(negedge clk);
            chk("b2b_gnt", 32'(gnt_o), 32'd1);
            tick();
            $display("txn back-to-back read word%0d", i);
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        tick();

        // Backpressure: two grants, then hold
        set_in(1'b1, BASE, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_gnt0", 32'(gnt_o), 32'd1);
        tick();
        set_in(1'b1, BASE + 32'd4, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_gnt1", 32'(gnt_o), 32'd1);
        tick();
        set_in(1'b1, BASE + 32'd8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_gnt", 32'(gnt_o), 32'd0);
            chk("bp_hold_rdata", rdata_o, 32'hA500_0000);
            tick();
        end
        set_in(1'b1, BASE + 32'd8, 1'b0, 1'b1);
        @(negedge clk);
        chk("bp_rel_gnt", 32'(gnt_o), 32'd0);
        chk("bp_rel_rdata", rdata_o, 32'hA500_0000);
        tick();
        @(negedge clk);
        chk("bp_resume_gnt", 32'(gnt_o), 32'd1);
        chk("bp_drain_rdata", rdata_o, 32'hA500_0001);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("bp_last_rdata", rdata_o, 32'hA500_0002);
        tick();
        tick();
        $display("txn backpressure drain words 0,1,2");

        // Rejected accesses
        set_in(1'b1, BASE, 1'b1, 1'b1);
        @(negedge clk);
        chk("wr_gnt", 32'(gnt_o), 32'd1);
        chk("wr_rom_en", 32'(rom_en_o), 32'd0);
        tick();
        set_in(1'b1, BASE - 32'd4, 1'b0, 1'b1);
        @(negedge clk);
        chk("lo_gnt", 32'(gnt_o), 32'd1);
        chk("lo_rom_en", 32'(rom_en_o), 32'd0);
        chk("wr_rsp_err", 32'(err_o), 32'd1);
        chk("wr_rsp_data", rdata_o, 32'd0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("lo_rsp_err", 32'(err_o), 32'd1);
        chk("lo_rsp_data", rdata_o, 32'd0);
        tick();
        $display("txn write and below-window read rejected");

        set_in(1'b1, BASE + 32'd2, 1'b0, 1'b1);
        tick();
        set_in(1'b1, BASE + 32'd20, 1'b0, 1'b1);
        @(negedge clk);
        chk("mis_err", 32'(err_o), 32'd1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("mis_next_rdata", rdata_o, 32'hA500_0005);
        chk("mis_next_err", 32'(err_o), 32'd0);
        tick();
        $display("txn misaligned then word5");

        // Reset with a full buffer, right after an accept
        set_in(1'b1, BASE + 32'd12, 1'b0, 1'b0);
        tick();
        set_in(1'b1, BASE + 32'd16, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_rvalid", 32'(rvalid_o), 32'd0);
        chk("ar_gnt", 32'(gnt_o), 32'd0);
        chk("ar_rom_en", 32'(rom_en_o), 32'd0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        $display("txn async reset mid-transfer");
        single_read();

        for (int n = 0; n < 400; n++) begin
            int          kind;
            logic [31:0] a;
            logic        w;
            kind = $urandom_range(0, 9);
            w    = 1'b0;
            case (kind)
                0:       begin a = BASE + 32'($urandom_range(0, 1023) * 4); w = 1'b1; end
                1:       a = BASE - 32'($urandom_range(1, 64) * 4);
                2:       a = ROM_LIMIT + 32'($urandom_range(0, 64) * 4);
                3:       a = BASE + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(1, 3));
                default: a = BASE + 32'($urandom_range(0, 1023) * 4);
            endcase
            set_in(($urandom_range(0, 3) != 0), a, w, ($urandom_range(0, 2) != 0));
            tick();
            if (n % 50 == 0) $display("txn random cycle %0d addr=%h we=%0d", n, a, w);
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
